stbus_frame_ctrl: RTL and testbench

STBUS_FRAME_CTRL -- requirements
Module: stbus_frame_ctrl

---
 rtl/stbus_pkg.sv | 15 +
 rtl/stbus_edge_sync.sv | 30 +++
 rtl/stbus_frame_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_stbus_frame_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stbus_pkg.sv
// Shared types and default geometry for the ST-BUS frame controller.
package stbus_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int unsigned FRAME_LEN    = 512;
  localparam int unsigned POS_W        = $clog2(FRAME_LEN);
  localparam int unsigned DEF_CHANNELS = 32;
  localparam int unsigned DEF_BITS     = 8;
  localparam int unsigned DEF_WD_LIMIT = 64;

endpackage

// File: rtl/stbus_edge_sync.sv
// Two-flop synchronizer with a one-cycle toggle pulse on every level change.
module stbus_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic toggle
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle level after reset is high so a held-high pin produces no event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync   = sync_q;
  assign toggle = sync_q ^ prev_q;

endmodule

// File: rtl/stbus_frame_ctrl.sv
// ST-BUS frame alignment controller: tracks c4/f0, tracks bit/channel position.
// Optional c4 loss watchdog is built when STBUS_WATCHDOG_EN is defined.
module stbus_frame_ctrl
  import stbus_pkg::*;
#(
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned BITS     = DEF_BITS,
  parameter int unsigned WD_LIMIT = DEF_WD_LIMIT
) (
  input  logic       clk50,
  input  logic       reset_n,
  input  logic       f0,
  input  logic       c4,
  input  logic       enable,
  input  logic [4:0] chan_sel,
  input  logic       int_ack,
  output logic       tx_shift_en,
  output logic       rx_sample_en,
  output logic [2:0] bit_cnt,
  output logic [4:0] chan_cnt,
  output logic       slot_window,
  output logic       frame_start,
  output logic       cpu_int,
  output logic       frame_err,
  output logic       locked
);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(CHANNELS * BITS * 2 - 1);

  logic rst_meta;
  logic rst_n_int;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta  <= 1'b0;
      rst_n_int <= 1'b0;
    end else begin
      rst_meta  <= 1'b1;
      rst_n_int <= rst_meta;
    end
  end

  logic c4_lvl;
  logic c4_tog;
  logic f0_lvl;
  logic f0_tog_unused;

  stbus_edge_sync u_c4_sync (
    .clk    (clk50),
    .rst_n  (rst_n_int),
    .din    (c4),
    .sync   (c4_lvl),
    .toggle (c4_tog)
  );

  stbus_edge_sync u_f0_sync (
    .clk    (clk50),
    .rst_n  (rst_n_int),
    .din    (f0),
    .sync   (f0_lvl),
    .toggle (f0_tog_unused)
  );

  logic c4_rise;
  logic c4_fall;
  logic fs_event;
  logic wd_trip;

  assign c4_rise  = c4_tog & c4_lvl;
  assign c4_fall  = c4_tog & ~c4_lvl;
  assign fs_event = c4_fall & ~f0_lvl;

`ifdef STBUS_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WD_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt;

  // Saturates at the limit so a dead c4 trips exactly once.
  always_ff @(posedge clk50 or negedge rst_n_int) begin
    if (!rst_n_int) begin
      wd_cnt <= '0;
    end else if (c4_tog) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_W'(WD_LIMIT)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_trip = ~c4_tog & (wd_cnt == WD_W'(WD_LIMIT - 1));
`else
  localparam int unsigned WD_LIMIT_UNUSED = WD_LIMIT;

  assign wd_trip = 1'b0;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_nxt;
  logic [1:0]       miss;
  logic [1:0]       miss_nxt;
  logic             cpu_set;
  logic             at_last;

  assign at_last = (pos == POS_LAST);

  always_comb begin
    state_nxt    = state;
    pos_nxt      = pos;
    miss_nxt     = miss;
    cpu_set      = 1'b0;
    tx_shift_en  = 1'b0;
    rx_sample_en = 1'b0;
    frame_start  = 1'b0;
    frame_err    = 1'b0;

    if (c4_fall) begin
      pos_nxt = (fs_event || at_last) ? '0 : pos + 1'b1;
    end

    case (state)
      HUNT: begin
        miss_nxt = '0;
        if (enable && fs_event) begin
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        tx_shift_en  = c4_fall & ~pos_nxt[0];
        rx_sample_en = c4_rise & pos[0];
        if (fs_event) begin
          frame_start = 1'b1;
          frame_err   = ~at_last;
          miss_nxt    = '0;
        end else if (c4_fall && at_last) begin
          miss_nxt = miss + 1'b1;
          if (miss == 2'd1) begin
            state_nxt = HUNT;
          end
        end
        if (c4_fall && at_last) begin
          cpu_set = 1'b1;
        end
        if (wd_trip) begin
          frame_err = 1'b1;
          state_nxt = HUNT;
        end
        if (!enable) begin
          state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state   <= HUNT;
      pos     <= '0;
      miss    <= '0;
      cpu_int <= 1'b0;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
      miss  <= miss_nxt;
      // A wrap in the same cycle as the acknowledge keeps the interrupt set.
      if (cpu_set) begin
        cpu_int <= 1'b1;
      end else if (int_ack) begin
        cpu_int <= 1'b0;
      end
    end
  end

  assign bit_cnt     = pos[3:1];
  assign chan_cnt    = pos[8:4];
  assign locked      = (state == LOCKED);
  assign slot_window = locked & (chan_cnt == chan_sel);

endmodule

// File: tb/tb_stbus_frame_ctrl.sv
// Randomized bench for stbus_frame_ctrl with a frame-level behavioural model.
module tb_stbus_frame_ctrl;

  logic       clk50 = 1'b0;
  logic       reset_n = 1'b1;
  logic       f0 = 1'b1;
  logic       c4 = 1'b1;
  logic       enable = 1'b1;
  logic [4:0] chan_sel = 5'd5;
  logic       int_ack;
  logic       int_ack_man = 1'b0;
  logic       ack_arm = 1'b0;

  logic       tx_shift_en;
  logic       rx_sample_en;
  logic [2:0] bit_cnt;
  logic [4:0] chan_cnt;
  logic       slot_window;
  logic       frame_start;
  logic       cpu_int;
  logic       frame_err;
  logic       locked;

  assign int_ack = int_ack_man | (ack_arm & frame_start);

  stbus_frame_ctrl #(.CHANNELS(32), .BITS(8), .WD_LIMIT(64)) dut (
    .clk50        (clk50),
    .reset_n      (reset_n),
    .f0           (f0),
    .c4           (c4),
    .enable       (enable),
    .chan_sel     (chan_sel),
    .int_ack      (int_ack),
    .tx_shift_en  (tx_shift_en),
    .rx_sample_en (rx_sample_en),
    .bit_cnt      (bit_cnt),
    .chan_cnt     (chan_cnt),
    .slot_window  (slot_window),
    .frame_start  (frame_start),
    .cpu_int      (cpu_int),
    .frame_err    (frame_err),
    .locked       (locked)
  );

  always #10 clk50 = ~clk50;

  int      n_checks = 0;
  int      n_pass = 0;
  int      got_tx = 0, got_rx = 0, got_fs = 0, got_err = 0;
  int      l_tx = 0, l_rx = 0, l_fs = 0, l_err = 0;
  int      e_tx = 0, e_rx = 0, e_fs = 0, e_err = 0;
  int      tx_since = 0;
  longint  fs_times[$];
  int      tx_per_frame[$];
  longint  err_time = 0;
  longint  t_edge = 0;
  int      slot_falls = 0;

  int      m_pos = 0;
  bit      m_locked = 0;
  int      m_miss = 0;
  bit      m_cpu = 0;

  always @(negedge clk50) begin
    got_tx  <= got_tx + int'(tx_shift_en);
    got_rx  <= got_rx + int'(rx_sample_en);
    got_fs  <= got_fs + int'(frame_start);
    got_err <= got_err + int'(frame_err);
    if (frame_err) err_time <= $time;
    if (frame_start) begin
      fs_times.push_back($time);
      tx_per_frame.push_back(tx_since);
      tx_since <= int'(tx_shift_en);
    end else begin
      tx_since <= tx_since + int'(tx_shift_en);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  task automatic chk_range(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got >= lo && got <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, got, lo, hi, $time);
  endtask

  // Frame rules applied once per c4 falling edge, f0 level as driven.
  task automatic model_fall(input bit fs);
    bit was;
    bit nxt;
    if (!enable) m_locked = 0;
    was = m_locked;
    nxt = was;
    if (was) begin
      if (fs) begin
        e_fs++;
        if (m_pos != 511) e_err++;
        m_miss = 0;
      end else if (m_pos == 511) begin
        m_miss++;
        if (m_miss >= 2) begin
          nxt = 0;
          m_miss = 0;
        end
      end
      if (m_pos == 511) m_cpu = 1;
    end else begin
      m_miss = 0;
      if (fs && enable) nxt = 1;
    end
    m_pos = fs ? 0 : (m_pos + 1) % 512;
    if (was && (m_pos % 2) == 0) e_tx++;
    m_locked = nxt;
  endtask

  task automatic model_rise();
    if (!enable) m_locked = 0;
    if (m_locked && (m_pos % 2) == 1) e_rx++;
  endtask

  task automatic compare();
    chk("bit_cnt", int'(bit_cnt), (m_pos / 2) % 8);
    chk("chan_cnt", int'(chan_cnt), m_pos / 16);
    chk("locked", int'(locked), int'(m_locked));
    chk("slot_window", int'(slot_window), (m_locked && (m_pos / 16) == int'(chan_sel)) ? 1 : 0);
    chk("cpu_int", int'(cpu_int), int'(m_cpu));
    chk("tx_shift_en_pulses", got_tx - l_tx, e_tx);
    chk("rx_sample_en_pulses", got_rx - l_rx, e_rx);
    chk("frame_start_pulses", got_fs - l_fs, e_fs);
    chk("frame_err_pulses", got_err - l_err, e_err);
    l_tx = got_tx; l_rx = got_rx; l_fs = got_fs; l_err = got_err;
    e_tx = 0; e_rx = 0; e_fs = 0; e_err = 0;
  endtask

  // One c4 period (244 ns); f0 changes together with the falling edge.
  task automatic c4_period(input bit f0_low, input bit do_ack);
    f0 = f0_low ? 1'b0 : 1'b1;
    c4 = 1'b0;
    t_edge = $time;
    model_fall(f0_low);
    #100;
    compare();
    if (slot_window) slot_falls++;
    #22;
    c4 = 1'b1;
    t_edge = $time;
    model_rise();
    #100;
    compare();
    if (do_ack) begin
      int_ack_man = 1'b1;
      #20;
      int_ack_man = 1'b0;
      m_cpu = 0;
      #2;
    end else begin
      #22;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tx_shift_en"}, int'(tx_shift_en), 0);
    chk({tag, "_rx_sample_en"}, int'(rx_sample_en), 0);
    chk({tag, "_bit_cnt"}, int'(bit_cnt), 0);
    chk({tag, "_chan_cnt"}, int'(chan_cnt), 0);
    chk({tag, "_slot_window"}, int'(slot_window), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_cpu_int"}, int'(cpu_int), 0);
    chk({tag, "_frame_err"}, int'(frame_err), 0);
    chk({tag, "_locked"}, int'(locked), 0);
  endtask

  initial begin
    int pre;
    int err0;

    #5 reset_n = 1'b0;
    #90;
    check_all_zero("reset");
    #8 reset_n = 1'b1;
    #200;

    pre = $urandom_range(5, 40);
    repeat (pre) c4_period(0, 0);

    for (int fr = 0; fr < 3; fr++) begin
      c4_period(1, 0);
      if (fr == 0) chk("locked_after_first_f0", int'(locked), 1);
      slot_falls = 0;
      repeat (511) c4_period(0, 0);
      chk("slot_falls_per_frame", slot_falls, 16);
    end
    c4_period(1, 0);
    chk("frame_start_count", fs_times.size(), 3);
    if (fs_times.size() >= 3) begin
      chk_range("frame_period_ns", int'(fs_times[1] - fs_times[0]), 124908, 124948);
      chk_range("frame_period2_ns", int'(fs_times[2] - fs_times[1]), 124908, 124948);
      chk("tx_per_frame_a", tx_per_frame[1], 256);
      chk("tx_per_frame_b", tx_per_frame[2], 256);
    end

    repeat (300) c4_period(0, 0);
    err0 = got_err;
    c4_period(1, 0);
    chk("inject_frame_err", got_err - err0, 1);
    chk("inject_bit_cnt", int'(bit_cnt), 0);
    chk("inject_chan_cnt", int'(chan_cnt), 0);
    chk("inject_locked", int'(locked), 1);
    repeat (511) c4_period(0, 0);
    c4_period(1, 0);

    c4_period(0, 1);
    chk("cpu_int_cleared", int'(cpu_int), 0);
    repeat (511 - m_pos) c4_period(0, 0);
    ack_arm = 1'b1;
    c4_period(1, 0);
    ack_arm = 1'b0;
    chk("cpu_int_set_wins", int'(cpu_int), 1);
    c4_period(0, 1);
    chk("cpu_int_ack_clears", int'(cpu_int), 0);

    repeat (511 - m_pos) c4_period(0, 0);
    c4_period(0, 0);
    chk("locked_after_one_miss", int'(locked), 1);
    repeat (511) c4_period(0, 0);
    c4_period(0, 0);
    chk("locked_after_two_misses", int'(locked), 0);
    repeat (100) c4_period(0, 0);
    c4_period(1, 0);
    chk("relocked_after_f0", int'(locked), 1);

    for (int i = 0; i < 700; i++) begin
      bit f0l;
      bit ack;
      if ($urandom_range(0, 99) == 0) chan_sel = 5'($urandom_range(0, 31));
      if (enable == 1'b0) enable = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 299) == 0) enable = 1'b0;
      f0l = (m_pos == 511) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 399) == 0);
      ack = ($urandom_range(0, 49) == 0);
      c4_period(f0l, ack);
    end

    enable = 1'b1;
`ifdef STBUS_WATCHDOG_EN
    c4_period(1, 0);
    repeat (10) c4_period(0, 0);
    chk("wd_pre_locked", int'(locked), 1);
    err0 = got_err;
    for (int i = 0; i < 200; i++) begin
      #20;
      if (got_err != err0) break;
    end
    chk("wd_frame_err_count", got_err - err0, 1);
    chk_range("wd_latency_ns", int'(err_time - t_edge), 1280, 1360);
    chk("wd_locked", int'(locked), 0);
    m_locked = 0;
    l_err = got_err;
`endif

    c4_period(1, 0);
    repeat (37) c4_period(0, 0);
    chk("pre_reset_locked", int'(locked), 1);
    reset_n = 1'b0;
    #1;
    check_all_zero("midframe_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
